// File: rtl/prog_step_counter.sv
// Programmable step counter: a prescaled tick applies a signed-direction step
// to an up/down counter with wrap-or-saturate overflow handling.
module prog_step_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DIV_FAST = 250000,
   parameter int unsigned DIV_SLOW = 25000000,
   parameter int unsigned DIVW     = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             speed,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] step,
   input  logic             dir,
   input  logic             sat,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [DIVW-1:0]  LIM_FAST = DIVW'(DIV_FAST - 1);
   localparam logic [DIVW-1:0]  LIM_SLOW = DIVW'(DIV_SLOW - 1);
   localparam logic [WIDTH-1:0] CNT_MAX  = '1;

   logic [DIVW-1:0]  div_cnt;
   logic [DIVW-1:0]  div_lim;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] step_cnt;
   logic             step_wrap;
   logic             step_ovf;

   // Tick is a clock-enable; >= lets a slow-to-fast switch fire immediately
   always_comb begin
      div_lim = speed ? LIM_FAST : LIM_SLOW;
      tick    = enable & ~rst & (div_cnt >= div_lim);
   end

   // Next count for a step, with carry/borrow detected in WIDTH+1 bits
   always_comb begin
      sum       = {1'b0, count} + {1'b0, step};
      diff      = {1'b0, count} - {1'b0, step};
      step_cnt  = sum[WIDTH-1:0];
      step_wrap = 1'b0;
      step_ovf  = 1'b0;
      if (!dir) begin
         if (sum[WIDTH]) begin
            if (sat) begin
               step_cnt = CNT_MAX;
               step_ovf = 1'b1;
            end else begin
               step_wrap = 1'b1;
            end
         end
      end else begin
         step_cnt = diff[WIDTH-1:0];
         if (diff[WIDTH]) begin
            if (sat) begin
               step_cnt = '0;
               step_ovf = 1'b1;
            end else begin
               step_wrap = 1'b1;
            end
         end
      end
   end

   // Prescaler: runs while enabled, restarts on tick, held at zero otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (!enable || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIVW'(1);
      end
   end

   // Counter, wrap pulse and sticky overflow; load beats tick, set beats clear
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         wrap  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (load) begin
            count <= load_value;
         end else if (tick) begin
            count <= step_cnt;
            wrap  <= step_wrap;
         end
         ovf <= (ovf & ~clr_ovf) | (tick & ~load & step_ovf);
      end
   end

endmodule
